// File: rtl/execute_stage.sv
// execute_stage: E stage of the five-stage pipeline. It runs the ALU operation,
// forms the branch target and the write-register select, and registers the
// results into the E/M boundary. MUL is a 32-step shift-and-add that holds
// stallE high and sends bubbles into M until the product is ready.
//
// Ports
//   clk, rstn          clock; synchronous active-low reset
//   rfweE..rfdselE     E-stage control bits
//   aluselE            ALU operation select
//   RFRD1E, RFRD2E     operands A and B
//   rtE, rdE           destination candidates (bits [4:0] used)
//   simmE              sign-extended immediate
//   pcoutE             PC+4 of the instruction
//   flushE             kill the instruction in E
//   stallE             combinational freeze request for upstream stages
//   *M                 registered E/M boundary outputs
module execute_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rfweE,
  input  logic        mtorfselE,
  input  logic        dmweE,
  input  logic        branchE,
  input  logic        aluinselE,
  input  logic        rfdselE,
  input  logic [2:0]  aluselE,
  input  logic [31:0] RFRD1E,
  input  logic [31:0] RFRD2E,
  input  logic [31:0] rtE,
  input  logic [31:0] rdE,
  input  logic [31:0] simmE,
  input  logic [31:0] pcoutE,
  input  logic        flushE,
  output logic        stallE,
  output logic        rfweM,
  output logic        mtorfselM,
  output logic        dmweM,
  output logic        branchM,
  output logic        zeroM,
  output logic [31:0] aluoutM,
  output logic [31:0] writedataM,
  output logic [31:0] pcbranchM,
  output logic [4:0]  writeregM
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mcand, mcand_nxt;
  logic [DW-1:0] mplier, mplier_nxt;
  logic [DW-1:0] acc, acc_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          bubble;

  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] result;
  logic [DW-1:0] branch_tgt;
  logic [RW-1:0] wreg;

  // Only the low five bits of the destination fields name a register.
  logic unused_bits;
  assign unused_bits = ^{rtE[DW-1:RW], rdE[DW-1:RW]};

  assign op_b       = aluinselE ? simmE : RFRD2E;
  assign branch_tgt = pcoutE + {simmE[DW-3:0], 2'b00};
  assign wreg       = rfdselE ? rdE[RW-1:0] : rtE[RW-1:0];

  // Single-cycle ALU; MUL is produced by the iterative datapath instead.
  always_comb begin
    alu_res = '0;
    case (aluselE)
      OP_AND:  alu_res = RFRD1E & op_b;
      OP_OR:   alu_res = RFRD1E | op_b;
      OP_ADD:  alu_res = RFRD1E + op_b;
      OP_XOR:  alu_res = RFRD1E ^ op_b;
      OP_NOR:  alu_res = ~(RFRD1E | op_b);
      OP_SUB:  alu_res = RFRD1E - op_b;
      OP_SLT:  alu_res = DW'($signed(RFRD1E) < $signed(op_b));
      default: alu_res = '0;
    endcase
  end

  // In DONE the E inputs are still held by the stall, so only the value differs.
  assign result = (state == ST_DONE) ? acc : alu_res;

  // Next-state, stall and bubble decode; flush overrides every state.
  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    count_nxt  = count;
    stallE     = 1'b0;
    bubble     = 1'b0;
    if (flushE) begin
      state_nxt = ST_IDLE;
      bubble    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aluselE == OP_MUL) begin
            state_nxt  = ST_BUSY;
            mcand_nxt  = RFRD1E;
            mplier_nxt = op_b;
            acc_nxt    = '0;
            count_nxt  = '0;
            stallE     = 1'b1;
            bubble     = 1'b1;
          end
        end
        ST_BUSY: begin
          stallE = 1'b1;
          bubble = 1'b1;
          if (mplier[0]) begin
            acc_nxt = acc + mcand;
          end
          mcand_nxt  = {mcand[DW-2:0], 1'b0};
          mplier_nxt = {1'b0, mplier[DW-1:1]};
          count_nxt  = count + CW'(1);
          if (count == CW'(DW - 1)) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, multiplier datapath and E/M boundary registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
      rfweM      <= 1'b0;
      mtorfselM  <= 1'b0;
      dmweM      <= 1'b0;
      branchM    <= 1'b0;
      zeroM      <= 1'b0;
      aluoutM    <= '0;
      writedataM <= '0;
      pcbranchM  <= '0;
      writeregM  <= '0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      count  <= count_nxt;
      if (bubble) begin
        rfweM      <= 1'b0;
        mtorfselM  <= 1'b0;
        dmweM      <= 1'b0;
        branchM    <= 1'b0;
        zeroM      <= 1'b0;
        aluoutM    <= '0;
        writedataM <= '0;
        pcbranchM  <= '0;
        writeregM  <= '0;
      end else begin
        rfweM      <= rfweE;
        mtorfselM  <= mtorfselE;
        dmweM      <= dmweE;
        branchM    <= branchE;
        zeroM      <= (result == '0);
        aluoutM    <= result;
        writedataM <= RFRD2E;
        pcbranchM  <= branch_tgt;
        writeregM  <= wreg;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rfweE, mtorfselE, dmweE, branchE, aluinselE, rfdselE;
  logic [2:0]  aluselE;
  logic [31:0] RFRD1E, RFRD2E, rtE, rdE, simmE, pcoutE;
  logic        flushE;
  logic        stallE;
  logic        rfweM, mtorfselM, dmweM, branchM, zeroM;
  logic [31:0] aluoutM, writedataM, pcbranchM;
  logic [4:0]  writeregM;

  execute_stage dut (
    .clk(clk), .rstn(rstn),
    .rfweE(rfweE), .mtorfselE(mtorfselE), .dmweE(dmweE), .branchE(branchE),
    .aluinselE(aluinselE), .rfdselE(rfdselE), .aluselE(aluselE),
    .RFRD1E(RFRD1E), .RFRD2E(RFRD2E), .rtE(rtE), .rdE(rdE),
    .simmE(simmE), .pcoutE(pcoutE), .flushE(flushE), .stallE(stallE),
    .rfweM(rfweM), .mtorfselM(mtorfselM), .dmweM(dmweM), .branchM(branchM),
    .zeroM(zeroM), .aluoutM(aluoutM), .writedataM(writedataM),
    .pcbranchM(pcbranchM), .writeregM(writeregM)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] MUL = 3'b011;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [105:0] m_obs;
  assign m_obs = {rfweM, mtorfselM, dmweM, branchM, zeroM,
                  aluoutM, writedataM, pcbranchM, writeregM};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference ALU straight from the operation table.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Expected M contents for the instruction currently on the E inputs.
  function automatic logic [105:0] m_ref();
    logic [31:0] r;
    r = alu_ref(aluselE, RFRD1E, aluinselE ? simmE : RFRD2E);
    return {rfweE, mtorfselE, dmweE, branchE, (r == 32'd0), r, RFRD2E,
            pcoutE + simmE * 32'd4, rfdselE ? rdE[4:0] : rtE[4:0]};
  endfunction

  task automatic rand_fields();
    rfweE = 1'($urandom); mtorfselE = 1'($urandom); dmweE = 1'($urandom);
    branchE = 1'($urandom); aluinselE = 1'($urandom); rfdselE = 1'($urandom);
    aluselE = 3'($urandom); RFRD1E = $urandom; RFRD2E = $urandom;
    rtE = $urandom; rdE = $urandom; simmE = $urandom; pcoutE = $urandom;
    flushE = 1'b0;
  endtask

  // Present one instruction (called #1 after an edge) and check it through M.
  task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic flush, input string tag);
    logic [105:0] exp;
    int stalls;
    aluselE = op; RFRD1E = a; RFRD2E = b; flushE = flush;
    exp = flush ? 106'd0 : m_ref();
    #1;
    if (op == MUL && !flush) begin
      stalls = 0;
      while (stallE === 1'b1 && stalls < 40) begin
        stalls++;
        @(posedge clk); #1;
        check({tag, "_bubble"}, 128'(m_obs), 128'd0);
      end
      check({tag, "_stall_len"}, 128'(stalls), 128'd33);
    end else begin
      check({tag, "_stall"}, 128'(stallE), 128'd0);
    end
    @(posedge clk); #1;
    check(tag, 128'(m_obs), 128'(exp));
    flushE = 1'b0;
  endtask

  logic [31:0] sweep_exp [8];
  logic [2:0]  op;
  logic [31:0] a, b;

  initial begin
    sweep_exp = '{32'h5, 32'hFFFF_FFFF, 32'h4, 32'h0, 32'hFFFF_FFFA, 32'h0, 32'h6, 32'h0};

    // Reset with random inputs
    rand_fields();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_m", 128'(m_obs), 128'd0);
    rstn = 1'b1;
    rand_fields();
    exec(3'd2, 32'd10, 32'd20, 1'b0, "post_reset_add");

    // ALU sweep, register operand B
    for (int i = 0; i < 8; i++) begin
      if (i == 3) continue;
      rand_fields();
      aluinselE = 1'b0;
      exec(3'(i), 32'h5, 32'hFFFF_FFFF, 1'b0, $sformatf("sweep_op%0d", i));
      check($sformatf("sweep_val%0d", i), 128'(aluoutM), 128'(sweep_exp[i]));
    end

    // SUB of equal operands sets zero
    rand_fields();
    aluinselE = 1'b0;
    exec(3'd6, 32'h1234_5678, 32'h1234_5678, 1'b0, "sub_eq");
    check("sub_eq_zero", 128'(zeroM), 128'd1);

    // Immediate operand and branch target
    rand_fields();
    aluinselE = 1'b1; simmE = 32'hFFFF_FFFC; pcoutE = 32'h100; rfdselE = 1'b0; rtE = 32'd9;
    exec(3'd2, 32'h0000_1000, 32'h0, 1'b0, "imm_add");
    check("imm_pcbranch", 128'(pcbranchM), 128'h0F0);
    check("imm_writereg", 128'(writeregM), 128'd9);
    check("imm_aluout", 128'(aluoutM), 128'h0FFC);

    // Back-to-back multiplies
    rand_fields();
    aluinselE = 1'b0; rfweE = 1'b1;
    exec(MUL, 32'h0001_0003, 32'h0000_0007, 1'b0, "mul1");
    check("mul1_val", 128'(aluoutM), 128'h0007_0015);
    check("mul1_rfwe", 128'(rfweM), 128'd1);
    rand_fields();
    aluinselE = 1'b0;
    exec(MUL, 32'hFFFF_FFFF, 32'h2, 1'b0, "mul2");
    check("mul2_val", 128'(aluoutM), 128'hFFFF_FFFE);

    // MUL killed in its first cycle never starts
    rand_fields();
    exec(MUL, $urandom, $urandom, 1'b1, "mul_flush_idle");

    // Flush in BUSY cycle 10
    rand_fields();
    aluselE = MUL;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("flush_busy_stall_before", 128'(stallE), 128'd1);
    flushE = 1'b1;
    #1;
    check("flush_busy_stall", 128'(stallE), 128'd0);
    @(posedge clk); #1;
    check("flush_busy_m", 128'(m_obs), 128'd0);
    flushE = 1'b0;
    rand_fields();
    exec(3'd2, $urandom, $urandom, 1'b0, "after_flush_add");

    // Reset in BUSY cycle 5
    rand_fields();
    aluselE = MUL;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    aluselE = 3'd2;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    check("rst_busy_stall", 128'(stallE), 128'd0);
    check("rst_busy_m", 128'(m_obs), 128'd0);
    rand_fields();
    exec(3'd2, $urandom, $urandom, 1'b0, "after_rst_add");

    // Random mix
    for (int i = 0; i < 60; i++) begin
      rand_fields();
      op = 3'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) aluinselE = 1'b0;
      exec(op, a, b, ($urandom_range(0, 7) == 0), $sformatf("rand%0d_op%0d", i, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
